fmul_stream: RTL
================

Name: fmul_stream

Overview:
Parametrised, fully pipelined floating-point multiplier. It is the next generation of the team's bf16 multiplier, generalised to any IEEE-style format and defaulting to bf16. New over the previous block:
- AXI-stream style backpressure (valid/ready) on both inputs and the output.
- Selectable rounding mode.
- IEEE exception flags.
- Correct invalid-operation handling (inf*0).
- Asynchronous reset.
It sits in the accelerator datapath between the operand buffers and the accumulate stage.

Parameters:
EXP_W, 8, exponent field width (3..11).
MAN_W, 7, stored mantissa field width (2..23).
W, 1+EXP_W+MAN_W, total word width (derived, localparam).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
a_tdata  in  W  operand A {sign, exp, man}.
a_tvalid  in  1  A valid.
a_tready  out  1  A ready.
b_tdata  in  W  operand B.
b_tvalid  in  1  B valid.
b_tready  out  1  B ready.
rnd_mode  in  2  0=RNE, 1=RTZ, 2=RUP (toward +inf), 3=RDN (toward -inf); sampled with the operands.
result_tdata  out  W  product.
result_tvalid  out  1  product valid.
result_tready  in  1  downstream ready.
result_tflags  out  4  {invalid, overflow, underflow, inexact}, aligned with result_tdata.

Behaviour:
Reset:
- rst asserted: all stage valid bits, result_tvalid, result_tdata and result_tflags go to 0 immediately.
- Reset mid-operation discards in-flight products.
- No output is produced until new operands are accepted after rst deasserts.

Pipeline and handshake:
- 4 stages: S1 unpack/classify, S2 mantissa multiply and exponent add, S3 normalise/round, S4 pack/output register.
- Latency is exactly 4 cycles from the accepting edge to result_tvalid when result_tready stays high.
- Global advance: adv = ~result_tvalid | result_tready.
- Stages hold all contents when adv=0 (pipeline freeze; no bubble collapse required).
- a_tready = b_tready = adv.
- Join: a transfer occurs only when a_tvalid & b_tvalid & adv. If only one operand is valid, nothing is consumed and the valid side simply waits.
- While result_tvalid & ~result_tready, result_tdata and result_tflags stay stable.
- Full throughput: one product per cycle when no backpressure.

Arithmetic:
- bias = 2^(EXP_W-1)-1.
- Exponent math uses signed EXP_W+2 bits: e = ea + eb - bias.
- Product of {1,ma}*{1,mb} is 2*MAN_W+2 bits. If its MSB is set, shift right by 1 and increment e.
- Guard bit = first dropped bit; sticky = OR of the remaining dropped bits.
- Rounding increment:
  - RNE: g & (r|s|lsb).
  - RTZ: 0.
  - RUP: ~sign & (g|s).
  - RDN: sign & (g|s).
- Mantissa carry-out on rounding increments e.
- inexact = g|s for any finite non-overflow result.

Special cases (priority order):
1. Either input NaN, or inf*0: canonical NaN {0, all-ones exp, 1 followed by zeros}. invalid=1 only for inf*0 or a signalling NaN (mantissa MSB=0).
2. Either input inf: sign-correct inf, no flags.
3. Zero or denormal input: treated as zero (flush-to-zero); result is sign-correct zero, no flags.
4. Post-round e >= 2^EXP_W-1 is overflow; overflow=1 and inexact=1. Result:
   - RNE: inf.
   - RTZ: max finite.
   - RUP: +inf if positive, else -max finite.
   - RDN: -inf if negative, else +max finite.
5. Post-round e <= 0: flush to sign-correct zero; underflow=1, inexact=1.

Result sign is always sa^sb, including NaN-free zero and inf cases.

Decomposition:
- Package fp_pkg holds:
  - rounding-mode constants RM_RNE/RM_RTZ/RM_RUP/RM_RDN;
  - flag bit indices FL_INEXACT=0, FL_UNDERFLOW=1, FL_OVERFLOW=2, FL_INVALID=3;
  - bias and canonical-NaN helper functions parameterised by EXP_W/MAN_W.
- One sub-module, fp_round: inputs mantissa, g, s, sign, rnd_mode; outputs rounded mantissa, carry and inexact. It is combinational and used in S3, and is reusable by the planned adder.

Test Plan:
- bf16, RNE: 0x3FC0 * 0x4040 (1.5*3.0), result_tready=1 → 0x4090 exactly 4 cycles later, flags 0.
- 0x3F81*0x3F81:
  - RNE → 0x3F82, inexact=1.
  - RTZ → 0x3F82.
  - RUP → 0x3F83.
  - RDN of 0xBF81*0x3F81 → 0xBF83.
- 0x7F7F * 0x4000:
  - RNE → 0x7F80, flags overflow|inexact.
  - RTZ → 0x7F7F.
  - 0xFF7F*0x4000 with RUP → 0xFF7F.
- Specials:
  - 0x7F80 * 0x0000 → 0x7FC0, invalid=1.
  - 0xFF80 * 0x3F80 → 0xFF80.
  - 0x0001 (denormal) * 0x4000 → 0x0000.
  - 0x0080 * 0x0080 → 0x0000 with underflow|inexact.
- Backpressure: stream 8 random pairs back-to-back, drop result_tready for 3 cycles mid-stream, and delay b_tvalid 2 cycles relative to a_tvalid → all 8 results delivered in order, matching the reference model, with output stable while stalled.
- EXP_W=8, MAN_W=23 (FP32): 0x3FC00000*0x40400000 → 0x40900000. Assert rst in the middle of a 4-deep burst → result_tvalid=0 next cycle, no stale outputs afterwards.

Source files
------------

// File: rtl/fp_pkg.sv
// Purpose : shared constants, operand-class struct and format helpers for the
//           parametrised floating-point datapath blocks (multiplier, adder).
// Latency : n/a (package). Backpressure: n/a.
package fp_pkg;

  // Rounding modes, as carried on rnd_mode.
  localparam logic [1:0] RM_RNE = 2'd0;  // nearest, ties to even
  localparam logic [1:0] RM_RTZ = 2'd1;  // toward zero
  localparam logic [1:0] RM_RUP = 2'd2;  // toward +inf
  localparam logic [1:0] RM_RDN = 2'd3;  // toward -inf

  // Bit positions inside the 4-bit exception flag vector.
  localparam int FL_INEXACT   = 0;
  localparam int FL_UNDERFLOW = 1;
  localparam int FL_OVERFLOW  = 2;
  localparam int FL_INVALID   = 3;

  // Special-operand classification travelling down the pipe with a product.
  typedef struct packed {
    logic nan;   // result is the canonical NaN
    logic inv;   // invalid-operation flag (inf*0 or signalling NaN input)
    logic inf;   // result is a signed infinity
    logic zero;  // result is a signed zero (zero or flushed denormal input)
  } fp_cls_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, all-ones exponent, mantissa 100..0.
  // Returned 64 bits wide; callers cast down to their word width.
  function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_round.sv
// Purpose : mantissa rounding increment for a given rounding mode.
// Latency : combinational.
// Backpressure: none (pure function of its inputs).
// Ports   : man/g/s = truncated mantissa, guard bit, sticky bit; sign and
//           rnd_mode select the increment; man_out/carry = rounded mantissa and
//           its carry-out; inexact = any nonzero bit was dropped.
module fp_round
  import fp_pkg::*;
#(
  parameter int MAN_W = 7
) (
  input  logic [MAN_W-1:0] man,
  input  logic             g,
  input  logic             s,
  input  logic             sign,
  input  logic [1:0]       rnd_mode,
  output logic [MAN_W-1:0] man_out,
  output logic             carry,
  output logic             inexact
);

  logic inc;

  always_comb begin
    inc = 1'b0;
    case (rnd_mode)
      RM_RNE:  inc = g & (s | man[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign & (g | s);
      RM_RDN:  inc = sign & (g | s);
      default: inc = 1'b0;
    endcase
  end

  // A carry-out means the mantissa wrapped to zero: the caller bumps the
  // exponent, which is exactly 1.11..1 + ulp = 10.0..0.
  assign {carry, man_out} = {1'b0, man} + {{MAN_W{1'b0}}, inc};
  assign inexact          = g | s;

endmodule

// File: rtl/fmul_stream.sv
// Purpose : pipelined IEEE-style floating-point multiplier (default bf16), FTZ.
// Latency : 4 register stages; result valid on the 4th edge counting the accepting edge.
// Backpressure: whole pipe freezes while result is valid and not taken; a/b ready = advance.
// Ports   : a_*/b_* operand streams (joined: both valid to transfer), rnd_mode
//           sampled with the operands; result_* product stream with
//           result_tflags = {invalid, overflow, underflow, inexact}.
module fmul_stream
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 7,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a_tdata,
  input  logic         a_tvalid,
  output logic         a_tready,
  input  logic [W-1:0] b_tdata,
  input  logic         b_tvalid,
  output logic         b_tready,
  input  logic [1:0]   rnd_mode,
  output logic [W-1:0] result_tdata,
  output logic         result_tvalid,
  input  logic         result_tready,
  output logic [3:0]   result_tflags
);

  localparam int EW2 = EXP_W + 2;
  localparam int PW  = 2 * MAN_W + 2;
  localparam logic signed [EW2-1:0] BIAS   = EW2'(fp_bias(EXP_W));
  localparam logic signed [EW2-1:0] E_OVF  = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] E_ZERO = '0;
  localparam logic [W-1:0] CANON_NAN = W'(fp_canon_nan(EXP_W, MAN_W));

  // Single global enable: every stage moves together or not at all.
  logic adv;
  assign adv      = ~result_tvalid | result_tready;
  assign a_tready = adv;
  assign b_tready = adv;

  // ---------------- S1: unpack / classify ----------------
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   ma, mb;
  logic               a_ones, b_ones, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  fp_cls_t            cls_in;

  assign {sa, ea, ma} = a_tdata;
  assign {sb, eb, mb} = b_tdata;
  assign a_ones = &ea;
  assign b_ones = &eb;
  assign a_nan  = a_ones & (|ma);
  assign b_nan  = b_ones & (|mb);
  assign a_inf  = a_ones & ~(|ma);
  assign b_inf  = b_ones & ~(|mb);
  assign a_zero = ~(|ea);  // denormals flush to zero here
  assign b_zero = ~(|eb);

  always_comb begin
    cls_in      = '0;
    cls_in.nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    cls_in.inv  = (a_nan & ~ma[MAN_W-1]) | (b_nan & ~mb[MAN_W-1]) |
                  (a_inf & b_zero) | (b_inf & a_zero);
    cls_in.inf  = a_inf | b_inf;
    cls_in.zero = a_zero | b_zero;
  end

  logic             s1_vld, s1_sign;
  logic [EXP_W-1:0] s1_ea, s1_eb;
  logic [MAN_W:0]   s1_ma, s1_mb;
  fp_cls_t          s1_cls;
  logic [1:0]       s1_rm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0; s1_sign <= 1'b0; s1_ea <= '0; s1_eb <= '0;
      s1_ma  <= '0;   s1_mb   <= '0;   s1_cls <= '0; s1_rm <= '0;
    end else if (adv) begin
      s1_vld  <= a_tvalid & b_tvalid;
      s1_sign <= sa ^ sb;
      s1_ea   <= ea;
      s1_eb   <= eb;
      s1_ma   <= {1'b1, ma};
      s1_mb   <= {1'b1, mb};
      s1_cls  <= cls_in;
      s1_rm   <= rnd_mode;
    end
  end

  // ---------------- S2: mantissa multiply, exponent add ----------------
  logic                  s2_vld, s2_sign;
  logic signed [EW2-1:0] s2_e;
  logic [PW-1:0]         s2_prod;
  fp_cls_t               s2_cls;
  logic [1:0]            s2_rm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld <= 1'b0; s2_sign <= 1'b0; s2_e <= '0; s2_prod <= '0;
      s2_cls <= '0;   s2_rm   <= '0;
    end else if (adv) begin
      s2_vld  <= s1_vld;
      s2_sign <= s1_sign;
      s2_e    <= $signed({2'b00, s1_ea}) + $signed({2'b00, s1_eb}) - BIAS;
      s2_prod <= PW'(s1_ma) * PW'(s1_mb);
      s2_cls  <= s1_cls;
      s2_rm   <= s1_rm;
    end
  end

  // ---------------- S3: normalise / round ----------------
  // The product of two [1,2) significands lies in [1,4); its top bit says
  // whether the leading one sits one place higher than usual.
  logic                  n_g, n_s;
  logic [MAN_W-1:0]      n_man;
  logic signed [EW2-1:0] n_e, r_e;
  logic [MAN_W-1:0]      r_man;
  logic                  r_carry, r_inx;

  always_comb begin
    n_man = '0;
    n_g   = 1'b0;
    n_s   = 1'b0;
    n_e   = s2_e;
    if (s2_prod[PW-1]) begin
      n_man = s2_prod[PW-2 -: MAN_W];
      n_g   = s2_prod[MAN_W];
      n_s   = |s2_prod[MAN_W-1:0];
      n_e   = s2_e + EW2'(1);
    end else begin
      n_man = s2_prod[PW-3 -: MAN_W];
      n_g   = s2_prod[MAN_W-1];
      n_s   = |s2_prod[MAN_W-2:0];
    end
  end

  fp_round #(.MAN_W(MAN_W)) u_round (
    .man      (n_man),
    .g        (n_g),
    .s        (n_s),
    .sign     (s2_sign),
    .rnd_mode (s2_rm),
    .man_out  (r_man),
    .carry    (r_carry),
    .inexact  (r_inx)
  );

  assign r_e = n_e + $signed({{(EW2-1){1'b0}}, r_carry});

  logic                  s3_vld, s3_sign, s3_inx;
  logic signed [EW2-1:0] s3_e;
  logic [MAN_W-1:0]      s3_man;
  fp_cls_t               s3_cls;
  logic [1:0]            s3_rm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_vld <= 1'b0; s3_sign <= 1'b0; s3_inx <= 1'b0; s3_e <= '0;
      s3_man <= '0;   s3_cls  <= '0;   s3_rm  <= '0;
    end else if (adv) begin
      s3_vld  <= s2_vld;
      s3_sign <= s2_sign;
      s3_inx  <= r_inx;
      s3_e    <= r_e;
      s3_man  <= r_man;
      s3_cls  <= s2_cls;
      s3_rm   <= s2_rm;
    end
  end

  // ---------------- S4: special-case select, pack, output register ----------------
  logic [W-1:0] inf_val, max_fin, nxt_data;
  logic [3:0]   nxt_flags;

  assign inf_val = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign max_fin = {s3_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

  always_comb begin
    nxt_data  = '0;
    nxt_flags = '0;
    if (s3_cls.nan) begin
      nxt_data              = CANON_NAN;
      nxt_flags[FL_INVALID] = s3_cls.inv;
    end else if (s3_cls.inf) begin
      nxt_data = inf_val;
    end else if (s3_cls.zero) begin
      nxt_data = {s3_sign, {(W-1){1'b0}}};
    end else if (s3_e >= E_OVF) begin
      nxt_flags[FL_OVERFLOW] = 1'b1;
      nxt_flags[FL_INEXACT]  = 1'b1;
      // Directed modes saturate to max finite when rounding away from inf.
      case (s3_rm)
        RM_RNE:  nxt_data = inf_val;
        RM_RTZ:  nxt_data = max_fin;
        RM_RUP:  nxt_data = s3_sign ? max_fin : inf_val;
        RM_RDN:  nxt_data = s3_sign ? inf_val : max_fin;
        default: nxt_data = inf_val;
      endcase
    end else if (s3_e <= E_ZERO) begin
      nxt_data                = {s3_sign, {(W-1){1'b0}}};
      nxt_flags[FL_UNDERFLOW] = 1'b1;
      nxt_flags[FL_INEXACT]   = 1'b1;
    end else begin
      nxt_data              = {s3_sign, s3_e[EXP_W-1:0], s3_man};
      nxt_flags[FL_INEXACT] = s3_inx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_tvalid <= 1'b0;
      result_tdata  <= '0;
      result_tflags <= '0;
    end else if (adv) begin
      result_tvalid <= s3_vld;
      result_tdata  <= nxt_data;
      result_tflags <= nxt_flags;
    end
  end

endmodule
